// File: rtl/sys_cmd_master.sv
// sys_cmd_master: host-side command-frame initiator for the system-controller
// byte protocol. Latches one request, streams its command frame to a byte
// sink, collects the 0/1/2-byte response from a byte source and reports it
// as one result word, or a timeout pulse when the controller goes silent.
module sys_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [1:0]              REQ_CMD,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA,
  input  logic [DATA_WIDTH-1:0]   REQ_OP_A,
  input  logic [DATA_WIDTH-1:0]   REQ_OP_B,
  input  logic [FUN_WIDTH-1:0]    REQ_FUN,
  output logic [7:0]              TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  input  logic [7:0]              RX_DATA,
  input  logic                    RX_VALID,
  output logic                    RSP_VALID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_TIMEOUT,
  output logic                    BUSY
);

  // Silence counter: counts 0..TIMEOUT_CYCLES-1 and never wraps.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CMD_WR    = 2'b00;
  localparam logic [1:0] CMD_RD    = 2'b01;
  localparam logic [1:0] CMD_ALU   = 2'b10;
  localparam logic [1:0] CMD_ALU_N = 2'b11;

  localparam logic [7:0] HDR_WR    = 8'hAA;
  localparam logic [7:0] HDR_RD    = 8'hBB;
  localparam logic [7:0] HDR_ALU   = 8'hCC;
  localparam logic [7:0] HDR_ALU_N = 8'hDD;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_LSB,
    WAIT_MSB,
    RESP
  } state_t;

  state_t                  state;
  logic [1:0]              idx;
  logic [CNT_W-1:0]        to_cnt;
  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_timeout;

  // Shadow copy of the request; the frame is built only from these.
  logic [1:0]              cmd_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   op_a_q;
  logic [DATA_WIDTH-1:0]   op_b_q;
  logic [FUN_WIDTH-1:0]    fun_q;

  // Byte at position idx of the frame for the given command and fields.
  function automatic logic [7:0] frame_byte(
    input logic [1:0]            cmd,
    input logic [1:0]            pos,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] op_a,
    input logic [DATA_WIDTH-1:0] op_b,
    input logic [FUN_WIDTH-1:0]  fun
  );
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      CMD_WR: begin
        case (pos)
          2'd0:    b = HDR_WR;
          2'd1:    b = 8'(addr);
          default: b = 8'(data);
        endcase
      end
      CMD_RD: begin
        if (pos == 2'd0) b = HDR_RD;
        else             b = 8'(addr);
      end
      CMD_ALU: begin
        case (pos)
          2'd0:    b = HDR_ALU;
          2'd1:    b = 8'(op_a);
          2'd2:    b = 8'(op_b);
          default: b = 8'(fun);
        endcase
      end
      default: begin
        if (pos == 2'd0) b = HDR_ALU_N;
        else             b = 8'(fun);
      end
    endcase
    return b;
  endfunction

  // Index of the final byte of each frame type.
  function automatic logic [1:0] frame_last(input logic [1:0] cmd);
    logic [1:0] last;
    case (cmd)
      CMD_WR:  last = 2'd2;
      CMD_RD:  last = 2'd1;
      CMD_ALU: last = 2'd3;
      default: last = 2'd1;
    endcase
    return last;
  endfunction

  // Capture request fields when a request is accepted.
  always_ff @(posedge CLK) begin
    if (state == IDLE && REQ_VALID) begin
      cmd_q  <= REQ_CMD;
      addr_q <= REQ_ADDR;
      data_q <= REQ_DATA;
      op_a_q <= REQ_OP_A;
      op_b_q <= REQ_OP_B;
      fun_q  <= REQ_FUN;
    end
  end

  // Protocol FSM with registered TX and response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= 2'd0;
      to_cnt      <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            idx      <= 2'd0;
            tx_valid <= 1'b1;
            tx_data  <= frame_byte(REQ_CMD, 2'd0, REQ_ADDR, REQ_DATA,
                                   REQ_OP_A, REQ_OP_B, REQ_FUN);
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid && TX_READY) begin
            if (idx == frame_last(cmd_q)) begin
              tx_valid <= 1'b0;
              if (cmd_q == CMD_WR) begin
                rsp_data  <= '0;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end else begin
                to_cnt <= '0;
                state  <= WAIT_LSB;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= frame_byte(cmd_q, idx + 2'd1, addr_q, data_q,
                                    op_a_q, op_b_q, fun_q);
            end
          end
        end
        WAIT_LSB: begin
          // An arriving byte takes priority over timeout expiry.
          if (RX_VALID) begin
            rsp_data      <= '0;
            rsp_data[7:0] <= RX_DATA;
            to_cnt        <= '0;
            if (cmd_q == CMD_RD) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT_MSB;
            end
          end else if (to_cnt == CNT_LAST) begin
            rsp_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        WAIT_MSB: begin
          if (RX_VALID) begin
            rsp_data[15:8] <= RX_DATA;
            to_cnt         <= '0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end else if (to_cnt == CNT_LAST) begin
            rsp_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign REQ_READY   = (state == IDLE);
  assign BUSY        = (state != IDLE);
  assign TX_VALID    = tx_valid;
  assign TX_DATA     = tx_data;
  assign RSP_VALID   = rsp_valid;
  assign RSP_DATA    = rsp_data;
  assign RSP_TIMEOUT = rsp_timeout;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Testbench for sys_cmd_master: directed protocol scenarios followed by
// randomized requests, all checked against a frame/response model.
module tb_sys_cmd_master;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_CMD;
  logic [3:0]  REQ_ADDR;
  logic [7:0]  REQ_DATA;
  logic [7:0]  REQ_OP_A;
  logic [7:0]  REQ_OP_B;
  logic [3:0]  REQ_FUN;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RSP_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_TIMEOUT;
  logic        BUSY;

  sys_cmd_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CMD(REQ_CMD),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_OP_A(REQ_OP_A),
    .REQ_OP_B(REQ_OP_B), .REQ_FUN(REQ_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_rsp;
  logic [7:0]  frame_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame for a request, straight from the byte-protocol table.
  task automatic build_frame(input logic [1:0] cmd, input logic [3:0] addr,
                             input logic [7:0] data, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] fun);
    frame_q.delete();
    case (cmd)
      2'b00: begin
        frame_q.push_back(8'hAA); frame_q.push_back({4'h0, addr}); frame_q.push_back(data);
      end
      2'b01: begin
        frame_q.push_back(8'hBB); frame_q.push_back({4'h0, addr});
      end
      2'b10: begin
        frame_q.push_back(8'hCC); frame_q.push_back(a); frame_q.push_back(b);
        frame_q.push_back({4'h0, fun});
      end
      default: begin
        frame_q.push_back(8'hDD); frame_q.push_back({4'h0, fun});
      end
    endcase
  endtask

  // One response-byte window: give the byte after d silent cycles, or let
  // TO silent cycles elapse, which must produce the timeout pulse.
  task automatic rx_phase(input bit give, input int d, input logic [7:0] val,
                          output bit timed_out);
    timed_out = 1'b0;
    for (int c = 0; c < TO; c++) begin
      if (give && c == d) begin
        RX_VALID = 1'b1;
        RX_DATA  = val;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
        chk("no_timeout_on_byte", RSP_TIMEOUT, 1'b0);
        return;
      end
      tick();
      if (c == TO - 1) begin
        chk("timeout_pulse", RSP_TIMEOUT, 1'b1);
        chk("timeout_no_valid", RSP_VALID, 1'b0);
        chk("timeout_idle", BUSY, 1'b0);
        timed_out = 1'b1;
      end else begin
        chk("timeout_early", RSP_TIMEOUT, 1'b0);
      end
    end
  endtask

  task automatic finish_ok();
    chk("rsp_valid", RSP_VALID, 1'b1);
    chk("rsp_data", RSP_DATA, model_rsp);
    tick();
    chk("rsp_valid_single", RSP_VALID, 1'b0);
    chk("ready_after_rsp", REQ_READY, 1'b1);
  endtask

  task automatic finish_timeout();
    chk("rsp_data_kept", RSP_DATA, model_rsp);
    tick();
    chk("timeout_single", RSP_TIMEOUT, 1'b0);
    chk("ready_after_to", REQ_READY, 1'b1);
  endtask

  task automatic do_txn(input logic [1:0] cmd, input logic [3:0] addr,
                        input logic [7:0] data, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] fun,
                        input logic [15:0] stall_mask, input int give,
                        input int d_lsb, input int d_msb,
                        input logic [7:0] lsb, input logic [7:0] msb);
    int n_rsp;
    int i;
    int cyc;
    bit acc;
    bit to;
    build_frame(cmd, addr, data, a, b, fun);
    n_rsp = (cmd == 2'b00) ? 0 : (cmd == 2'b01) ? 1 : 2;
    chk("idle_ready", REQ_READY, 1'b1);
    chk("idle_busy", BUSY, 1'b0);
    REQ_CMD = cmd; REQ_ADDR = addr; REQ_DATA = data;
    REQ_OP_A = a; REQ_OP_B = b; REQ_FUN = fun;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    REQ_CMD = 2'($urandom); REQ_ADDR = 4'($urandom); REQ_DATA = 8'($urandom);
    REQ_OP_A = 8'($urandom); REQ_OP_B = 8'($urandom); REQ_FUN = 4'($urandom);
    i = 0;
    cyc = 0;
    while (i < frame_q.size() && cyc < 40) begin
      chk("tx_valid", TX_VALID, 1'b1);
      chk($sformatf("tx_byte%0d", i), TX_DATA, frame_q[i]);
      chk("busy_send", BUSY, 1'b1);
      TX_READY = (cyc < 16) ? !stall_mask[cyc] : 1'b1;
      RX_VALID = 1'($urandom_range(0, 1));
      RX_DATA  = 8'($urandom);
      acc = TX_READY;
      tick();
      if (acc) i++;
      cyc++;
    end
    if (cyc >= 40) chk("send_bound", 1'b0, 1'b1);
    TX_READY = 1'b0;
    RX_VALID = 1'b0;
    chk("tx_idle_after_frame", TX_VALID, 1'b0);
    if (n_rsp == 0) begin
      model_rsp = 16'h0000;
      finish_ok();
    end else begin
      chk("wait_busy", BUSY, 1'b1);
      chk("no_early_rsp", RSP_VALID, 1'b0);
      rx_phase(give >= 1, d_lsb, lsb, to);
      if (to) begin
        finish_timeout();
      end else begin
        model_rsp = {8'h00, lsb};
        if (n_rsp == 1) begin
          finish_ok();
        end else begin
          chk("no_rsp_after_lsb", RSP_VALID, 1'b0);
          chk("partial_lsb", RSP_DATA, model_rsp);
          rx_phase(give >= 2, d_msb, msb, to);
          if (to) begin
            finish_timeout();
          end else begin
            model_rsp[15:8] = msb;
            finish_ok();
          end
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_CMD = 2'b00; REQ_ADDR = 4'h0;
    REQ_DATA = 8'h00; REQ_OP_A = 8'h00; REQ_OP_B = 8'h00; REQ_FUN = 4'h0;
    TX_READY = 1'b0; RX_DATA = 8'h00; RX_VALID = 1'b0;
    model_rsp = 16'h0000;
    tick();
    chk("rst_tx_valid", TX_VALID, 1'b0);
    chk("rst_tx_data", TX_DATA, 8'h00);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_data", RSP_DATA, 16'h0000);
    chk("rst_timeout", RSP_TIMEOUT, 1'b0);
    chk("rst_ready", REQ_READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;
    tick();

    // RX strobe while idle is dropped
    RX_VALID = 1'b1; RX_DATA = 8'h55;
    tick();
    RX_VALID = 1'b0;
    chk("idle_rx_busy", BUSY, 1'b0);
    chk("idle_rx_rsp", RSP_VALID, 1'b0);
    chk("idle_rx_data", RSP_DATA, 16'h0000);

    // write with a two-cycle mid-frame stall
    do_txn(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 16'h0006, 0, 0, 0, 8'h00, 8'h00);
    // read, response 10 cycles after the last TX byte
    do_txn(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 1, 10, 0, 8'h7E, 8'h00);
    // ALU with operands, two response bytes
    do_txn(2'b10, 4'h0, 8'h00, 8'h0F, 8'h11, 4'h2, 16'h0000, 2, 3, 2, 8'hFF, 8'h00);
    // ALU without operands, MSB never arrives
    do_txn(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 1, 4, 0, 8'h34, 8'h00);
    // bytes arriving exactly on the expiry cycle
    do_txn(2'b10, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h7, 16'h0000, 2, TO - 1, TO - 1, 8'h12, 8'h9C);
    // read with no response at all
    do_txn(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 0, 0, 0, 8'h00, 8'h00);

    // reset in the middle of an ALU frame
    REQ_CMD = 2'b10; REQ_OP_A = 8'h5A; REQ_OP_B = 8'hA5; REQ_FUN = 4'h9;
    REQ_VALID = 1'b1; TX_READY = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    chk("abort_b0", TX_DATA, 8'hCC);
    tick();
    chk("abort_b1", TX_DATA, 8'h5A);
    tick();
    chk("abort_b2", TX_DATA, 8'hA5);
    chk("abort_b2_valid", TX_VALID, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0; TX_READY = 1'b0;
    model_rsp = 16'h0000;
    chk("abort_tx_valid", TX_VALID, 1'b0);
    chk("abort_tx_data", TX_DATA, 8'h00);
    chk("abort_rsp_valid", RSP_VALID, 1'b0);
    chk("abort_rsp_data", RSP_DATA, 16'h0000);
    chk("abort_timeout", RSP_TIMEOUT, 1'b0);
    chk("abort_ready", REQ_READY, 1'b1);
    chk("abort_busy", BUSY, 1'b0);
    do_txn(2'b10, 4'h0, 8'h00, 8'h21, 8'h43, 4'h5, 16'h0000, 2, 1, 1, 8'h65, 8'h87);

    // randomized requests
    for (int t = 0; t < 24; t++) begin
      logic [1:0] rc;
      int g;
      rc = 2'($urandom_range(0, 3));
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : 2;
      do_txn(rc, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             4'($urandom), 16'($urandom) & 16'h00FF, g,
             int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
             8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
